// File: rtl/issuequeue_div.sv
// Issue queue for the 16-bit divide unit: age-ordered shifting storage,
// CDB operand wakeup, oldest-ready selection and a post-issue gap timer.
module issuequeue_div #(
  parameter int DEPTH     = 4,
  parameter int ISSUE_GAP = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        dispatch_en,
  input  logic [15:0] dispatch_rsdata,
  input  logic [5:0]  dispatch_rstag,
  input  logic        dispatch_rsvalid,
  input  logic [15:0] dispatch_rtdata,
  input  logic [5:0]  dispatch_rttag,
  input  logic        dispatch_rtvalid,
  input  logic [5:0]  dispatch_rdtag,
  input  logic        cdb_valid,
  input  logic [5:0]  cdb_tag,
  input  logic [15:0] cdb_data,
  input  logic        div_busy,
  output logic        issuediv_enable,
  output logic [15:0] issuediv_rsdata,
  output logic [15:0] issuediv_rtdata,
  output logic [5:0]  issuediv_rdtag,
  output logic        queue_full,
  output logic [3:0]  queue_count
);

  localparam int GW = (ISSUE_GAP < 1) ? 1 : $clog2(ISSUE_GAP + 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(ISSUE_GAP);

  logic [DEPTH-1:0] valid_q, rsrdy_q, rtrdy_q;
  logic [15:0]      rsdata_q [DEPTH];
  logic [15:0]      rtdata_q [DEPTH];
  logic [5:0]       rstag_q  [DEPTH];
  logic [5:0]       rttag_q  [DEPTH];
  logic [5:0]       rdtag_q  [DEPTH];

  logic [DEPTH-1:0] valid_d, rsrdy_d, rtrdy_d;
  logic [15:0]      rsdata_d [DEPTH];
  logic [15:0]      rtdata_d [DEPTH];
  logic [5:0]       rstag_d  [DEPTH];
  logic [5:0]       rttag_d  [DEPTH];
  logic [5:0]       rdtag_d  [DEPTH];

  // Woken view of the entries, with one extra empty slot feeding the shift.
  logic [DEPTH:0]   w_valid, w_rsrdy, w_rtrdy;
  logic [15:0]      w_rsdata [DEPTH+1];
  logic [15:0]      w_rtdata [DEPTH+1];
  logic [5:0]       w_rstag  [DEPTH+1];
  logic [5:0]       w_rttag  [DEPTH+1];
  logic [5:0]       w_rdtag  [DEPTH+1];

  logic [3:0]       count_q, count_d, wr_idx;
  logic             full_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [DEPTH-1:0] ready;
  int               sel_idx;
  logic             do_issue, accept, fwd_rs, fwd_rt;

  assign ready    = valid_q & rsrdy_q & rtrdy_q;
  assign do_issue = (|ready) & ~div_busy & (gap_q == '0) & ~flush;
  assign accept   = dispatch_en & ~queue_full & ~flush;
  assign fwd_rs   = cdb_valid & (dispatch_rstag == cdb_tag);
  assign fwd_rt   = cdb_valid & (dispatch_rttag == cdb_tag);
  assign wr_idx   = do_issue ? count_q - 4'd1 : count_q;

  always_comb begin
    sel_idx = 0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ready[i]) sel_idx = i;
    end
  end

  always_comb begin
    w_valid[DEPTH]  = 1'b0;
    w_rsrdy[DEPTH]  = 1'b0;
    w_rtrdy[DEPTH]  = 1'b0;
    w_rsdata[DEPTH] = '0;
    w_rtdata[DEPTH] = '0;
    w_rstag[DEPTH]  = '0;
    w_rttag[DEPTH]  = '0;
    w_rdtag[DEPTH]  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_valid[i]  = valid_q[i];
      w_rstag[i]  = rstag_q[i];
      w_rttag[i]  = rttag_q[i];
      w_rdtag[i]  = rdtag_q[i];
      w_rsrdy[i]  = rsrdy_q[i];
      w_rtrdy[i]  = rtrdy_q[i];
      w_rsdata[i] = rsdata_q[i];
      w_rtdata[i] = rtdata_q[i];
      if (valid_q[i] && !rsrdy_q[i] && cdb_valid && rstag_q[i] == cdb_tag) begin
        w_rsrdy[i]  = 1'b1;
        w_rsdata[i] = cdb_data;
      end
      if (valid_q[i] && !rtrdy_q[i] && cdb_valid && rttag_q[i] == cdb_tag) begin
        w_rtrdy[i]  = 1'b1;
        w_rtdata[i] = cdb_data;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      int src;
      src = (do_issue && i >= sel_idx) ? i + 1 : i;
      valid_d[i]  = w_valid[src];
      rsrdy_d[i]  = w_rsrdy[src];
      rtrdy_d[i]  = w_rtrdy[src];
      rsdata_d[i] = w_rsdata[src];
      rtdata_d[i] = w_rtdata[src];
      rstag_d[i]  = w_rstag[src];
      rttag_d[i]  = w_rttag[src];
      rdtag_d[i]  = w_rdtag[src];
      if (accept && 4'(i) == wr_idx) begin
        valid_d[i]  = 1'b1;
        rstag_d[i]  = dispatch_rstag;
        rttag_d[i]  = dispatch_rttag;
        rdtag_d[i]  = dispatch_rdtag;
        rsrdy_d[i]  = dispatch_rsvalid | fwd_rs;
        rtrdy_d[i]  = dispatch_rtvalid | fwd_rt;
        rsdata_d[i] = (!dispatch_rsvalid && fwd_rs) ? cdb_data : dispatch_rsdata;
        rtdata_d[i] = (!dispatch_rtvalid && fwd_rt) ? cdb_data : dispatch_rtdata;
      end
      if (flush) valid_d[i] = 1'b0;
    end
    count_d = flush ? 4'd0 : count_q + {3'b000, accept} - {3'b000, do_issue};
    full_d  = (count_d == 4'(DEPTH));
    // Flush leaves the timer alone: an in-flight divide is still running.
    if (do_issue)          gap_d = GAP_LOAD;
    else if (gap_q != '0)  gap_d = gap_q - 1'b1;
    else                   gap_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q         <= '0;
      rsrdy_q         <= '0;
      rtrdy_q         <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rsdata_q[i] <= '0;
        rtdata_q[i] <= '0;
        rstag_q[i]  <= '0;
        rttag_q[i]  <= '0;
        rdtag_q[i]  <= '0;
      end
      count_q         <= '0;
      queue_full      <= 1'b0;
      gap_q           <= '0;
      issuediv_enable <= 1'b0;
      issuediv_rsdata <= '0;
      issuediv_rtdata <= '0;
      issuediv_rdtag  <= '0;
    end else begin
      valid_q    <= valid_d;
      rsrdy_q    <= rsrdy_d;
      rtrdy_q    <= rtrdy_d;
      for (int i = 0; i < DEPTH; i++) begin
        rsdata_q[i] <= rsdata_d[i];
        rtdata_q[i] <= rtdata_d[i];
        rstag_q[i]  <= rstag_d[i];
        rttag_q[i]  <= rttag_d[i];
        rdtag_q[i]  <= rdtag_d[i];
      end
      count_q         <= count_d;
      queue_full      <= full_d;
      gap_q           <= gap_d;
      issuediv_enable <= do_issue;
      if (do_issue) begin
        issuediv_rsdata <= rsdata_q[sel_idx];
        issuediv_rtdata <= rtdata_q[sel_idx];
        issuediv_rdtag  <= rdtag_q[sel_idx];
      end
    end
  end

  assign queue_count = count_q;

endmodule

// File: tb/tb_issuequeue_div.sv
// Bench for issuequeue_div: expected issues are queued at dispatch time and
// matched against every issue pulse; each scenario task checks timing inline.
module tb_issuequeue_div;
  logic        clk = 1'b0;
  logic        reset, flush, dispatch_en;
  logic [15:0] dispatch_rsdata, dispatch_rtdata, cdb_data;
  logic [5:0]  dispatch_rstag, dispatch_rttag, dispatch_rdtag, cdb_tag;
  logic        dispatch_rsvalid, dispatch_rtvalid, cdb_valid, div_busy;
  logic        issuediv_enable, queue_full;
  logic [15:0] issuediv_rsdata, issuediv_rtdata;
  logic [5:0]  issuediv_rdtag;
  logic [3:0]  queue_count;

  typedef struct packed {
    logic [15:0] rs;
    logic [15:0] rt;
    logic [5:0]  rd;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  issuequeue_div #(.DEPTH(4), .ISSUE_GAP(3)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .dispatch_en(dispatch_en),
    .dispatch_rsdata(dispatch_rsdata), .dispatch_rstag(dispatch_rstag),
    .dispatch_rsvalid(dispatch_rsvalid),
    .dispatch_rtdata(dispatch_rtdata), .dispatch_rttag(dispatch_rttag),
    .dispatch_rtvalid(dispatch_rtvalid),
    .dispatch_rdtag(dispatch_rdtag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .div_busy(div_busy),
    .issuediv_enable(issuediv_enable),
    .issuediv_rsdata(issuediv_rsdata), .issuediv_rtdata(issuediv_rtdata),
    .issuediv_rdtag(issuediv_rdtag),
    .queue_full(queue_full), .queue_count(queue_count)
  );

  always #5 clk = ~clk;

  // Scoreboard: every issue pulse must match the oldest outstanding expectation.
  always @(posedge clk) begin
    #1;
    if (issuediv_enable === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_issue got rs=%h rt=%h rd=%h with nothing expected",
                 issuediv_rsdata, issuediv_rtdata, issuediv_rdtag);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({issuediv_rsdata, issuediv_rtdata, issuediv_rdtag} !== e) begin
          failures++;
          $display("FAIL issue_data got rs=%h rt=%h rd=%h expected rs=%h rt=%h rd=%h",
                   issuediv_rsdata, issuediv_rtdata, issuediv_rdtag, e.rs, e.rt, e.rd);
        end
      end
    end
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_dispatch(input logic [15:0] rs, input logic [5:0] rstag, input logic rsv,
                                input logic [15:0] rt, input logic [5:0] rttag, input logic rtv,
                                input logic [5:0] rd);
    dispatch_en      = 1'b1;
    dispatch_rsdata  = rs;
    dispatch_rstag   = rstag;
    dispatch_rsvalid = rsv;
    dispatch_rtdata  = rt;
    dispatch_rttag   = rttag;
    dispatch_rtvalid = rtv;
    dispatch_rdtag   = rd;
  endtask

  task automatic idle_inputs();
    dispatch_en = 1'b0; dispatch_rsvalid = 1'b0; dispatch_rtvalid = 1'b0;
    dispatch_rsdata = '0; dispatch_rtdata = '0;
    dispatch_rstag = '0; dispatch_rttag = '0; dispatch_rdtag = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0; flush = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; div_busy = 1'b0;
    idle_inputs();
    step(2);
    checks++; if (issuediv_enable !== 1'b0) begin failures++; $display("FAIL reset_enable got %b expected 0", issuediv_enable); end
    checks++; if (issuediv_rsdata !== 16'h0) begin failures++; $display("FAIL reset_rsdata got %h expected 0000", issuediv_rsdata); end
    checks++; if (issuediv_rtdata !== 16'h0) begin failures++; $display("FAIL reset_rtdata got %h expected 0000", issuediv_rtdata); end
    checks++; if (issuediv_rdtag !== 6'h0) begin failures++; $display("FAIL reset_rdtag got %h expected 00", issuediv_rdtag); end
    checks++; if (queue_full !== 1'b0) begin failures++; $display("FAIL reset_full got %b expected 0", queue_full); end
    checks++; if (queue_count !== 4'd0) begin failures++; $display("FAIL reset_count got %0d expected 0", queue_count); end
    reset = 1'b0;
    step(1);
  endtask

  task automatic test_ready_dispatch();
    drive_dispatch(16'h0064, 6'h00, 1'b1, 16'h0005, 6'h00, 1'b1, 6'h12);
    sb.push_back('{rs: 16'h0064, rt: 16'h0005, rd: 6'h12});
    step(1);
    idle_inputs();
    checks++; if (queue_count !== 4'd1) begin failures++; $display("FAIL ready_count_after_dispatch got %0d expected 1", queue_count); end
    step(1);
    checks++; if (issuediv_enable !== 1'b1) begin failures++; $display("FAIL ready_issue got enable=%b expected 1", issuediv_enable); end
    checks++; if (queue_count !== 4'd0) begin failures++; $display("FAIL ready_count_after_issue got %0d expected 0", queue_count); end
    step(1);
    checks++; if (issuediv_enable !== 1'b0) begin failures++; $display("FAIL ready_pulse_width got enable=%b expected 0", issuediv_enable); end
    step(6);
  endtask

  task automatic test_cdb_wakeup();
    drive_dispatch(16'h0030, 6'h00, 1'b1, 16'h0000, 6'h07, 1'b0, 6'h21);
    sb.push_back('{rs: 16'h0030, rt: 16'h0003, rd: 6'h21});
    step(1);
    idle_inputs();
    step(3);
    cdb_valid = 1'b1; cdb_tag = 6'h07; cdb_data = 16'h0003;
    step(1);
    idle_inputs();
    checks++; if (issuediv_enable !== 1'b0) begin failures++; $display("FAIL wakeup_early got enable=%b expected 0", issuediv_enable); end
    step(1);
    checks++; if (issuediv_enable !== 1'b1) begin failures++; $display("FAIL wakeup_issue got enable=%b expected 1", issuediv_enable); end
    step(6);
  endtask

  task automatic test_oldest_gap();
    int n;
    logic seen;
    drive_dispatch(16'h0100, 6'h00, 1'b1, 16'h0010, 6'h00, 1'b1, 6'h01);
    sb.push_back('{rs: 16'h0100, rt: 16'h0010, rd: 6'h01});
    step(1);
    drive_dispatch(16'h0200, 6'h00, 1'b1, 16'h0020, 6'h00, 1'b1, 6'h02);
    sb.push_back('{rs: 16'h0200, rt: 16'h0020, rd: 6'h02});
    step(1);
    idle_inputs();
    checks++; if (issuediv_enable !== 1'b1) begin failures++; $display("FAIL oldest_first_issue got enable=%b expected 1", issuediv_enable); end
    n = 0; seen = 1'b0;
    while (!seen && n < 12) begin
      step(1);
      n++;
      seen = issuediv_enable;
    end
    checks++; if (!seen || n != 4) begin failures++; $display("FAIL gap_spacing got seen=%b cycles=%0d expected seen=1 cycles=4", seen, n); end
    step(6);
    div_busy = 1'b1;
    drive_dispatch(16'h0300, 6'h00, 1'b1, 16'h0030, 6'h00, 1'b1, 6'h03);
    sb.push_back('{rs: 16'h0300, rt: 16'h0030, rd: 6'h03});
    step(1);
    idle_inputs();
    step(10);
    checks++; if (queue_count !== 4'd1) begin failures++; $display("FAIL busy_hold_count got %0d expected 1", queue_count); end
    div_busy = 1'b0;
    step(1);
    checks++; if (issuediv_enable !== 1'b1) begin failures++; $display("FAIL busy_release_issue got enable=%b expected 1", issuediv_enable); end
    step(6);
  endtask

  task automatic test_full();
    int drained;
    for (int i = 0; i < 4; i++) begin
      drive_dispatch(16'h0000, 6'(8'h11 + i), 1'b0, 16'h0040 + 16'(i), 6'h00, 1'b1, 6'(8'h31 + i));
      step(1);
    end
    idle_inputs();
    checks++; if (queue_full !== 1'b1) begin failures++; $display("FAIL full_flag got %b expected 1", queue_full); end
    checks++; if (queue_count !== 4'd4) begin failures++; $display("FAIL full_count got %0d expected 4", queue_count); end
    drive_dispatch(16'h0500, 6'h00, 1'b1, 16'h0050, 6'h00, 1'b1, 6'h35);
    step(1);
    idle_inputs();
    checks++; if (queue_count !== 4'd4) begin failures++; $display("FAIL full_ignore_count got %0d expected 4", queue_count); end
    cdb_valid = 1'b1; cdb_tag = 6'h12; cdb_data = 16'h00AA;
    sb.push_back('{rs: 16'h00AA, rt: 16'h0041, rd: 6'h32});
    step(1);
    idle_inputs();
    step(1);
    checks++; if (issuediv_enable !== 1'b1) begin failures++; $display("FAIL full_mid_issue got enable=%b expected 1", issuediv_enable); end
    checks++; if (queue_count !== 4'd3) begin failures++; $display("FAIL full_shift_count got %0d expected 3", queue_count); end
    checks++; if (queue_full !== 1'b0) begin failures++; $display("FAIL full_clear got %b expected 0", queue_full); end
    sb.push_back('{rs: 16'h0111, rt: 16'h0040, rd: 6'h31});
    sb.push_back('{rs: 16'h0113, rt: 16'h0042, rd: 6'h33});
    sb.push_back('{rs: 16'h0114, rt: 16'h0043, rd: 6'h34});
    cdb_valid = 1'b1; cdb_tag = 6'h14; cdb_data = 16'h0114; step(1);
    cdb_tag = 6'h11; cdb_data = 16'h0111; step(1);
    cdb_tag = 6'h13; cdb_data = 16'h0113; step(1);
    idle_inputs();
    drained = 0;
    for (int i = 0; i < 30 && drained < 3; i++) begin
      step(1);
      if (issuediv_enable === 1'b1) drained++;
    end
    checks++; if (drained != 3 || queue_count !== 4'd0) begin failures++; $display("FAIL full_drain got issues=%0d count=%0d expected issues=3 count=0", drained, queue_count); end
    step(6);
  endtask

  task automatic test_forward();
    drive_dispatch(16'h0000, 6'h09, 1'b0, 16'h0007, 6'h00, 1'b1, 6'h3A);
    cdb_valid = 1'b1; cdb_tag = 6'h09; cdb_data = 16'hBEEF;
    sb.push_back('{rs: 16'hBEEF, rt: 16'h0007, rd: 6'h3A});
    step(1);
    idle_inputs();
    step(1);
    checks++; if (issuediv_enable !== 1'b1) begin failures++; $display("FAIL forward_issue got enable=%b expected 1", issuediv_enable); end
    step(6);
  endtask

  task automatic test_flush_reset();
    div_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_dispatch(16'h0600 + 16'(i), 6'h00, 1'b1, 16'h0060, 6'h00, 1'b1, 6'(8'h20 + i));
      step(1);
    end
    idle_inputs();
    checks++; if (queue_count !== 4'd3) begin failures++; $display("FAIL flush_pre_count got %0d expected 3", queue_count); end
    flush = 1'b1;
    drive_dispatch(16'h0700, 6'h00, 1'b1, 16'h0070, 6'h00, 1'b1, 6'h28);
    div_busy = 1'b0;
    step(1);
    idle_inputs();
    checks++; if (queue_count !== 4'd0) begin failures++; $display("FAIL flush_count got %0d expected 0", queue_count); end
    checks++; if (issuediv_enable !== 1'b0) begin failures++; $display("FAIL flush_no_issue got enable=%b expected 0", issuediv_enable); end
    step(6);
    drive_dispatch(16'h0800, 6'h00, 1'b1, 16'h0080, 6'h00, 1'b1, 6'h2A);
    sb.push_back('{rs: 16'h0800, rt: 16'h0080, rd: 6'h2A});
    step(1);
    drive_dispatch(16'h0900, 6'h00, 1'b1, 16'h0090, 6'h00, 1'b1, 6'h2B);
    step(1);
    idle_inputs();
    checks++; if (issuediv_enable !== 1'b1) begin failures++; $display("FAIL pre_reset_issue got enable=%b expected 1", issuediv_enable); end
    #1 reset = 1'b1;
    #1;
    checks++; if ({issuediv_enable, issuediv_rsdata, issuediv_rtdata, issuediv_rdtag} !== 39'h0)
      begin failures++; $display("FAIL async_reset_outputs got en=%b rs=%h rt=%h rd=%h expected all 0", issuediv_enable, issuediv_rsdata, issuediv_rtdata, issuediv_rdtag); end
    checks++; if (queue_count !== 4'd0) begin failures++; $display("FAIL async_reset_count got %0d expected 0", queue_count); end
    step(2);
    reset = 1'b0;
    step(10);
    checks++; if (queue_count !== 4'd0) begin failures++; $display("FAIL post_reset_count got %0d expected 0", queue_count); end
  endtask

  initial begin
    test_reset();
    test_ready_dispatch();
    test_cdb_wakeup();
    test_oldest_gap();
    test_full();
    test_forward();
    test_flush_reset();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_empty got %0d outstanding expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/issuequeue_div.md
Name: issuequeue_div

Overview:
- Reservation-station issue queue for the 16-bit divide unit in the out-of-order MIPS core.
- Accepts dispatched DIV/DIVU instructions and snoops the CDB for pending source operands.
- Selects the oldest entry whose operands are both ready and drives the divide issue interface: enable, rs/rt data and rd tag.
- Acts as the initiator of the divide-issue handshake and respects the divider's busy signal plus a fixed issue gap.

Parameters:
- DEPTH, 4: number of queue entries (2..8).
- ISSUE_GAP, 3: minimum cycles between issues, covering the divider busy-flag register delay.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- flush  in  1  synchronous branch-mispredict flush; invalidates all entries.
- dispatch_en  in  1  write one instruction this cycle.
- dispatch_rsdata  in  16  rs value, used when rsvalid=1.
- dispatch_rstag  in  6  rs producer tag, used when rsvalid=0.
- dispatch_rsvalid  in  1  rs value is ready.
- dispatch_rtdata  in  16  rt value.
- dispatch_rttag  in  6  rt producer tag.
- dispatch_rtvalid  in  1  rt value is ready.
- dispatch_rdtag  in  6  destination tag; 0 is reserved and never dispatched.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_tag  in  6  broadcast tag.
- cdb_data  in  16  broadcast value.
- div_busy  in  1  divider busy, active-high.
- issuediv_enable  out  1  one-cycle issue pulse, registered.
- issuediv_rsdata  out  16  dividend, registered.
- issuediv_rtdata  out  16  divisor, registered.
- issuediv_rdtag  out  6  destination tag, registered.
- queue_full  out  1  registered; all DEPTH entries valid.
- queue_count  out  4  number of valid entries, registered.

Behaviour:
- Reset (async, active-high) values:
  - All entries invalid.
  - issuediv_enable=0; issuediv_rsdata, issuediv_rtdata and issuediv_rdtag = 0.
  - queue_full=0, queue_count=0.
  - Gap counter = 0.
- Entry fields: valid, rsdata, rstag, rsrdy, rtdata, rttag, rtrdy, rdtag.
- Storage is an age-ordered shifting queue. Entry 0 is the oldest. Valid entries are always contiguous from index 0.
- CDB snoop, every cycle:
  - For each valid entry with rsrdy=0 and rstag==cdb_tag while cdb_valid=1: load rsdata=cdb_data and set rsrdy=1 at the clock edge. The rt operand is handled the same way independently.
  - Both operands may wake up in the same cycle.
- Dispatch forwarding: if dispatch_rsvalid=0 and cdb_valid=1 and dispatch_rstag==cdb_tag, the entry is written with rsrdy=1 and rsdata=cdb_data. The rt operand is handled the same way.
- Ready condition: valid & rsrdy & rtrdy, evaluated on registered entry state. An entry woken by the CDB in cycle N can issue at the earliest in cycle N+1.
- Issue condition: any ready entry, div_busy=0, gap counter == 0, and flush=0.
  - The lowest-index (oldest) ready entry is selected.
  - At the clock edge: outputs load that entry's rsdata, rtdata and rdtag, and issuediv_enable=1 for exactly one cycle.
  - The selected entry is removed and younger entries shift down by one.
  - Gap counter loads ISSUE_GAP.
- When not issuing: issuediv_enable=0, the data/tag outputs hold their last values, and the gap counter decrements (saturating at 0).
- Dispatch write slot:
  - With no issue in the same cycle, the new entry goes to index count.
  - With an issue in the same cycle, it goes to index count-1, after the shift.
- Dispatch while full:
  - If queue_full=1, dispatch_en is ignored, even when an issue frees a slot in the same cycle. The dispatcher must stall on queue_full.
- Count:
  - count_next = count + accepted dispatch − issue.
  - queue_full = (count_next == DEPTH), registered.
- Flush:
  - All entries are invalidated; count=0, full=0, issuediv_enable=0 next cycle.
  - Any same-cycle dispatch is dropped.
  - The gap counter keeps counting, because an in-flight divide remains busy.
- Mid-operation reset clears everything immediately. There is no pending issue after release.
- div_busy is sampled combinationally in the issue decision. While it is high, no issue occurs regardless of the gap counter.

Test Plan:
- Ready dispatch: empty queue, dispatch rs=0x0064 valid, rt=0x0005 valid, rdtag=0x12 with div_busy=0. Next cycle: issuediv_enable=1, rsdata=0x0064, rtdata=0x0005, rdtag=0x12; queue_count returns to 0.
- CDB wakeup: dispatch rt pending on tag 0x07. Three cycles later, CDB tag 0x07 data 0x0003. Required: issue exactly one cycle after the CDB cycle, with rtdata=0x0003; no issue before that.
- Oldest-first and gap: dispatch A (tag 0x01), then B (tag 0x02), both ready. A issues first. B issues no earlier than ISSUE_GAP=3 cycles later, and only once div_busy=0. Holding div_busy=1 delays B indefinitely.
- Full: four dispatches with rs pending → queue_full=1. A fifth dispatch is ignored. A CDB wakeup of entry 2 issues entry 2, then entries 3 and 4 shift down, leaving count=3.
- Dispatch-time forwarding: dispatch rstag=0x09 (not valid) in the same cycle as CDB tag 0x09 data 0xBEEF. The entry is ready immediately, and the issued rsdata=0xBEEF.
- Flush and reset: three entries valid, flush=1 with a concurrent dispatch → count=0 next cycle and no issue. Assert reset asynchronously mid-gap → all outputs 0 immediately, and no issue after release.
